// File: rtl/apb_slave_controller.sv
// ---------------------------------------------------------------------------
// apb_slave_controller
//   APB slave-side transfer sequencer: IDLE/SETUP/ACCESS FSM with programmable
//   wait states, address decode onto a small register map, and the register
//   storage itself (error counter, two payload words, data-size).
//
// Ports
//   pclk        in   clock
//   preset      in   synchronous active-high reset
//   psel_x      in   slave select
//   penable     in   APB enable (access phase)
//   pwrite      in   1 = write, 0 = read
//   paddr       in   3-bit word address
//   pwdata      in   write data
//   pstrb       in   byte-lane write strobes (only with APB_PSTRB_EN)
//   prdata      out  read data, non-zero only in the pready cycle of a read
//   pready      out  transfer completion (one cycle)
//   pslverr     out  error response, qualified by pready
//   payload     out  {word1, word0}
//   data_size   out  data-size register
//   size_commit out  one-cycle pulse after a successful data-size write
//
// Optional feature
//   `define APB_PSTRB_EN to add the pstrb port and per-byte-lane writes.
//   Without it every write updates all byte lanes.
// ---------------------------------------------------------------------------
module apb_slave_controller #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned WAIT_STATES        = 1,
  parameter int unsigned ERR_STATUS_ADDRESS = 1,
  parameter int unsigned PAYLOAD_ADDRESS    = 2,
  parameter int unsigned DATA_SIZE_ADDRESS  = 4
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel_x,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [2:0]              paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [2*DATA_WIDTH-1:0] payload,
  output logic [DATA_WIDTH-1:0]   data_size,
  output logic                    size_commit
);

  localparam int unsigned AW  = 3;
  localparam int unsigned CW  = 4;
  localparam int unsigned EW  = 8;
`ifdef APB_PSTRB_EN
  localparam int unsigned SW  = DATA_WIDTH / 8;
`endif

  localparam logic [AW-1:0] ADDR_ERR = AW'(ERR_STATUS_ADDRESS);
  localparam logic [AW-1:0] ADDR_PL0 = AW'(PAYLOAD_ADDRESS);
  localparam logic [AW-1:0] ADDR_PL1 = AW'(PAYLOAD_ADDRESS + 1);
  localparam logic [AW-1:0] ADDR_DS  = AW'(DATA_SIZE_ADDRESS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         xfer_addr_q, xfer_addr_d;
  logic                  xfer_write_q, xfer_write_d;
  logic [DATA_WIDTH-1:0] xfer_wdata_q, xfer_wdata_d;
`ifdef APB_PSTRB_EN
  logic [SW-1:0]         xfer_strb_q, xfer_strb_d;
`endif
  logic [DATA_WIDTH-1:0] payload0_q, payload0_d;
  logic [DATA_WIDTH-1:0] payload1_q, payload1_d;
  logic [DATA_WIDTH-1:0] data_size_q, data_size_d;
  logic [EW-1:0]         err_cnt_q, err_cnt_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  size_commit_q, size_commit_d;

  logic                  commit_c;
  logic                  cur_err_c;
  logic                  nxt_err_c;
  logic [DATA_WIDTH-1:0] old_word_c;
  logic [DATA_WIDTH-1:0] new_word_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  // Unmapped addresses and writes to the read-only error counter are errors.
  function automatic logic addr_err(input logic [AW-1:0] a, input logic wr);
    logic mapped;
    mapped = (a == ADDR_ERR) || (a == ADDR_PL0) || (a == ADDR_PL1) || (a == ADDR_DS);
    return !mapped || (wr && (a == ADDR_ERR));
  endfunction

`ifdef APB_PSTRB_EN
  // Byte-lane merge: strobed lanes take new data, the rest keep old data.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [SW-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < int'(SW); b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction
`endif

  // State and datapath registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      xfer_addr_q   <= '0;
      xfer_write_q  <= 1'b0;
      xfer_wdata_q  <= '0;
`ifdef APB_PSTRB_EN
      xfer_strb_q   <= '0;
`endif
      payload0_q    <= '0;
      payload1_q    <= '0;
      data_size_q   <= '0;
      err_cnt_q     <= '0;
      prdata_q      <= '0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      size_commit_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      xfer_addr_q   <= xfer_addr_d;
      xfer_write_q  <= xfer_write_d;
      xfer_wdata_q  <= xfer_wdata_d;
`ifdef APB_PSTRB_EN
      xfer_strb_q   <= xfer_strb_d;
`endif
      payload0_q    <= payload0_d;
      payload1_q    <= payload1_d;
      data_size_q   <= data_size_d;
      err_cnt_q     <= err_cnt_d;
      prdata_q      <= prdata_d;
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      size_commit_q <= size_commit_d;
    end
  end

  // Next-state, commit and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    xfer_addr_d   = xfer_addr_q;
    xfer_write_d  = xfer_write_q;
    xfer_wdata_d  = xfer_wdata_q;
`ifdef APB_PSTRB_EN
    xfer_strb_d   = xfer_strb_q;
`endif
    payload0_d    = payload0_q;
    payload1_d    = payload1_q;
    data_size_d   = data_size_q;
    err_cnt_d     = err_cnt_q;
    size_commit_d = 1'b0;
    commit_c      = 1'b0;
    old_word_c    = '0;
    new_word_c    = '0;
    rd_word_c     = '0;

    unique case (state_q)
      ST_IDLE: begin
        // psel_x with penable already high is a protocol violation: ignored.
        if (psel_x && !penable) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (!psel_x) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          state_d      = ST_ACCESS;
          cnt_d        = CW'(WAIT_STATES);
          xfer_addr_d  = paddr;
          xfer_write_d = pwrite;
          xfer_wdata_d = pwdata;
`ifdef APB_PSTRB_EN
          xfer_strb_d  = pstrb;
`endif
        end
      end
      ST_ACCESS: begin
        if (!psel_x) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          commit_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cur_err_c = addr_err(xfer_addr_q, xfer_write_q);

    // Counter tracks every error response seen on the bus, saturating.
    if (pready_q && pslverr_q && (err_cnt_q != {EW{1'b1}})) begin
      err_cnt_d = err_cnt_q + EW'(1);
    end

    if (xfer_addr_q == ADDR_PL0)      old_word_c = payload0_q;
    else if (xfer_addr_q == ADDR_PL1) old_word_c = payload1_q;
    else if (xfer_addr_q == ADDR_DS)  old_word_c = data_size_q;
`ifdef APB_PSTRB_EN
    new_word_c = lane_merge(old_word_c, xfer_wdata_q, xfer_strb_q);
`else
    new_word_c = xfer_wdata_q;
`endif

    if (commit_c && !cur_err_c) begin
      if (xfer_write_q) begin
        if (xfer_addr_q == ADDR_PL0) payload0_d = new_word_c;
        if (xfer_addr_q == ADDR_PL1) payload1_d = new_word_c;
        if (xfer_addr_q == ADDR_DS) begin
          data_size_d   = new_word_c;
          size_commit_d = 1'b1;
        end
      end else if (xfer_addr_q == ADDR_ERR) begin
        // Read-to-clear; a valid read never coincides with an increment.
        err_cnt_d = '0;
      end
    end

    // Outputs are computed one edge early so they are flop-driven in the
    // completion cycle (ACCESS with the wait counter at zero).
    pready_d  = (state_d == ST_ACCESS) && (cnt_d == '0);
    nxt_err_c = addr_err(xfer_addr_d, xfer_write_d);
    pslverr_d = pready_d && nxt_err_c;

    if (xfer_addr_d == ADDR_ERR)      rd_word_c = DATA_WIDTH'(err_cnt_q);
    else if (xfer_addr_d == ADDR_PL0) rd_word_c = payload0_q;
    else if (xfer_addr_d == ADDR_PL1) rd_word_c = payload1_q;
    else if (xfer_addr_d == ADDR_DS)  rd_word_c = data_size_q;

    prdata_d = (pready_d && !nxt_err_c && !xfer_write_d) ? rd_word_c : '0;
  end

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign payload     = {payload1_q, payload0_q};
  assign data_size   = data_size_q;
  assign size_commit = size_commit_q;

endmodule

// File: tb/tb_apb_slave_controller.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_controller
//   Self-checking bench. u_dut (WAIT_STATES=1) runs the transfer table and
//   corner sequences; u_dut3 (WAIT_STATES=3) shares the bus and is always cut
//   off by psel_x dropping before its counter expires, so it must never
//   complete a transfer.
// ---------------------------------------------------------------------------
module tb_apb_slave_controller;

  localparam int unsigned DW = 32;

  logic          pclk = 1'b0;
  logic          preset;
  logic          psel_x;
  logic          penable;
  logic          pwrite;
  logic [2:0]    paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;

  logic [DW-1:0]   prdata, prdata3;
  logic            pready, pready3;
  logic            pslverr, pslverr3;
  logic [2*DW-1:0] payload, payload3;
  logic [DW-1:0]   data_size, data_size3;
  logic            size_commit, size_commit3;

  apb_slave_controller #(.DATA_WIDTH(DW), .WAIT_STATES(1)) u_dut (
    .pclk        (pclk),
    .preset      (preset),
    .psel_x      (psel_x),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
`ifdef APB_PSTRB_EN
    .pstrb       (pstrb),
`endif
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .payload     (payload),
    .data_size   (data_size),
    .size_commit (size_commit)
  );

  apb_slave_controller #(.DATA_WIDTH(DW), .WAIT_STATES(3)) u_dut3 (
    .pclk        (pclk),
    .preset      (preset),
    .psel_x      (psel_x),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
`ifdef APB_PSTRB_EN
    .pstrb       (pstrb),
`endif
    .prdata      (prdata3),
    .pready      (pready3),
    .pslverr     (pslverr3),
    .payload     (payload3),
    .data_size   (data_size3),
    .size_commit (size_commit3)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        exp_commit;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        commit;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  int n_cmp  = 0;
  int n_fail = 0;
  logic seen_pready3 = 1'b0;

  always @(posedge pclk) begin
    if (pready3) seen_pready3 <= 1'b1;
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout/underflow, expected DUT response", name);
  endtask

  task automatic push_exp(input logic err, input logic [31:0] rdata, input logic commit);
    exp_t e;
    e.err    = err;
    e.rdata  = rdata;
    e.commit = commit;
    sb_q.push_back(e);
  endtask

  // One complete APB transfer; the expectation was pushed by the caller.
  task automatic run_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int   waits;
    exp_t e;
    psel_x  = 1'b1;
    penable = 1'b0;
    pwrite  = w;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    cyc();
    penable = 1'b1;
    cyc();
    waits = 0;
    while (!pready && waits < 20) begin
      waits++;
      cyc();
    end
    if (!pready) begin
      fail_now("pready_timeout");
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      psel_x  = 1'b0;
      penable = 1'b0;
      cyc();
      return;
    end
    chk("wait_cycles", 64'(waits), 64'd1);
    if (sb_q.size() == 0) begin
      fail_now("scoreboard_empty");
      e.err    = 1'b0;
      e.rdata  = '0;
      e.commit = 1'b0;
    end else begin
      e = sb_q.pop_front();
    end
    chk("pslverr", 64'(pslverr), 64'(e.err));
    chk("prdata", 64'(prdata), 64'(e.rdata));
    cyc();
    psel_x  = 1'b0;
    penable = 1'b0;
    chk("pready_one_cycle", 64'(pready), 64'd0);
    chk("prdata_after", 64'(prdata), 64'd0);
    chk("size_commit", 64'(size_commit), 64'(e.commit));
    cyc();
    chk("size_commit_pulse_end", 64'(size_commit), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_prdata"},      64'(prdata),      64'd0);
    chk({tag, "_pready"},      64'(pready),      64'd0);
    chk({tag, "_pslverr"},     64'(pslverr),     64'd0);
    chk({tag, "_size_commit"}, 64'(size_commit), 64'd0);
    chk({tag, "_payload"},     payload,          64'd0);
    chk({tag, "_data_size"},   64'(data_size),   64'd0);
    chk({tag, "_pready3"},     64'(pready3),     64'd0);
    chk({tag, "_payload3"},    payload3,         64'd0);
    chk({tag, "_data_size3"},  64'(data_size3),  64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p0_exp;

    //            wr    addr  wdata         strb  err   rdata         commit
    vecs[0]  = '{1'b1, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 3'd4, 32'h00000010, 4'hF, 1'b0, 32'h00000000, 1'b1};
    vecs[2]  = '{1'b0, 3'd4, 32'h00000000, 4'hF, 1'b0, 32'h00000010, 1'b0};
    vecs[3]  = '{1'b1, 3'd1, 32'h00000055, 4'hF, 1'b1, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b1, 3'd7, 32'h00000066, 4'hF, 1'b1, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b0, 3'd1, 32'h00000000, 4'hF, 1'b0, 32'h00000002, 1'b0};
    vecs[6]  = '{1'b0, 3'd1, 32'h00000000, 4'hF, 1'b0, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b1, 3'd3, 32'hCAFEF00D, 4'hF, 1'b0, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 3'd2, 32'h00000000, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 3'd3, 32'h00000000, 4'hF, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 32'h00000000, 4'hF, 1'b1, 32'h00000000, 1'b0};
    vecs[11] = '{1'b0, 3'd5, 32'h00000000, 4'hF, 1'b1, 32'h00000000, 1'b0};
    vecs[12] = '{1'b0, 3'd1, 32'h00000000, 4'hF, 1'b0, 32'h00000002, 1'b0};
    vecs[13] = '{1'b1, 3'd2, 32'h11223344, 4'hF, 1'b0, 32'h00000000, 1'b0};

    preset  = 1'b1;
    psel_x  = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    cyc();
    cyc();
    chk_all_zero("reset");
    preset = 1'b0;
    cyc();

    // Protocol violation in IDLE: psel_x with penable high must be ignored.
    psel_x  = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 3'd2;
    pwdata  = 32'hBAD0BAD0;
    for (int i = 0; i < 4; i++) cyc();
    chk("violation_pready", 64'(pready), 64'd0);
    psel_x  = 1'b0;
    penable = 1'b0;
    cyc();
    chk("violation_payload", payload, 64'd0);

    for (int i = 0; i < 14; i++) begin
      push_exp(vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_commit);
      run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
    end
    chk("table_payload", payload, {32'hCAFEF00D, 32'h11223344});
    chk("table_data_size", 64'(data_size), 64'h10);
    p0_exp = 32'h11223344;

`ifdef APB_PSTRB_EN
    push_exp(1'b0, 32'h0, 1'b0);
    run_xfer(1'b1, 3'd2, 32'hAABBCCDD, 4'b0101);
    push_exp(1'b0, 32'h11BB33DD, 1'b0);
    run_xfer(1'b0, 3'd2, 32'h0, 4'hF);
    push_exp(1'b0, 32'h0, 1'b1);
    run_xfer(1'b1, 3'd4, 32'h00000099, 4'b0000);
    chk("strb_zero_data_size", 64'(data_size), 64'h10);
    p0_exp = 32'h11BB33DD;
`endif

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      push_exp(1'b1, 32'h0, 1'b0);
      run_xfer(i[0], (i[0] ? 3'd7 : 3'd6), 32'(i), 4'hF);
    end
    push_exp(1'b0, 32'd255, 1'b0);
    run_xfer(1'b0, 3'd1, 32'h0, 4'hF);
    push_exp(1'b0, 32'd0, 1'b0);
    run_xfer(1'b0, 3'd1, 32'h0, 4'hF);
    chk("sat_payload_kept", payload, {32'hCAFEF00D, p0_exp});

    chk("dut3_payload_untouched", payload3, 64'd0);
    chk("dut3_data_size_untouched", 64'(data_size3), 64'd0);

    // One error so the counter is non-zero going into reset.
    push_exp(1'b1, 32'h0, 1'b0);
    run_xfer(1'b1, 3'd1, 32'h0, 4'hF);

    // psel_x drop in ACCESS before completion.
    psel_x  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 3'd2;
    pwdata  = 32'h12345678;
    cyc();
    penable = 1'b1;
    cyc();
    chk("abort_access_pready", 64'(pready), 64'd0);
    chk("abort_access_pready3", 64'(pready3), 64'd0);
    psel_x  = 1'b0;
    penable = 1'b0;
    cyc();
    chk("abort_pready", 64'(pready), 64'd0);
    chk("abort_pready3", 64'(pready3), 64'd0);
    cyc();
    chk("abort_pready_late", 64'(pready), 64'd0);
    chk("abort_payload", payload, {32'hCAFEF00D, p0_exp});
    chk("abort_size_commit", 64'(size_commit), 64'd0);

    // Reset asserted while in SETUP.
    psel_x  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 3'd4;
    pwdata  = 32'h77;
    cyc();
    preset  = 1'b1;
    penable = 1'b1;
    cyc();
    preset  = 1'b0;
    psel_x  = 1'b0;
    penable = 1'b0;
    chk_all_zero("midreset");
    cyc();
    chk_all_zero("postreset");

    push_exp(1'b0, 32'd0, 1'b0);
    run_xfer(1'b0, 3'd1, 32'h0, 4'hF);

    chk("dut3_never_ready", 64'(seen_pready3), 64'd0);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
